// File: rtl/inta_sequencer.sv
// Interrupt acknowledge sequencer: turns the PIC's INT into the two-pulse
// 8086 INTA handshake, captures the vector byte and hands it to the core.
module inta_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_in,
  input  logic       int_en,
  input  logic [7:0] d_in,
  output logic       inta,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic [7:0] vec_data,
  output logic       spurious,
  output logic       busy,
  output logic [7:0] ack_count
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             int_s;
  logic             pulse_last;
  logic             gap_last;
  logic             spurious_next;
  logic             accept;

  assign pulse_last = (cnt == PULSE_LAST);
  assign gap_last   = (cnt == GAP_LAST);
  assign vec_valid  = (state == HOLD);
  assign busy       = (state != IDLE);

  // NOTE: state elements use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      int_s <= 1'b0;
    end else begin
      sync1 <= int_in;
      int_s <= sync1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    spurious_next = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: if (int_s && int_en) state_next = ACK1;
      ACK1: begin
        if (pulse_last) begin
          if (int_s) begin
            state_next = GAP;
          end else begin
            state_next    = IDLE;
            spurious_next = 1'b1;
          end
        end
      end
      GAP:  if (gap_last) state_next = ACK2;
      ACK2: if (pulse_last) state_next = HOLD;
      HOLD: begin
        if (vec_ready) begin
          state_next = IDLE;
          accept     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // inta is registered from the next-state decode so it rises on the same
  // edge the FSM enters an acknowledge state, yet stays glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      inta      <= 1'b0;
      spurious  <= 1'b0;
      vec_data  <= 8'h00;
      ack_count <= 8'h00;
    end else begin
      state    <= state_next;
      inta     <= (state_next == ACK1) || (state_next == ACK2);
      spurious <= spurious_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (state == ACK1 || state == GAP || state == ACK2) begin
        cnt <= cnt + 1'b1;
      end
      if (state == ACK2 && state_next == HOLD) vec_data <= d_in;
      if (accept) ack_count <= ack_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: default instance plus a
// PULSE_W=3/GAP_W=2 instance driven from shared stimulus.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int_in;
  logic       int_en;
  logic       vec_ready;
  logic [7:0] d_in;
  logic [1:0] inta_v;
  logic [1:0] vv_v;
  logic [1:0] sp_v;
  logic [1:0] busy_v;
  logic [7:0] vd_v [2];
  logic [7:0] ac_v [2];

  int checks = 0;
  int errors = 0;
  int exp_ack [2];

  always #5 clk = ~clk;

  inta_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .int_in(int_in), .int_en(int_en), .d_in(d_in),
    .inta(inta_v[0]), .vec_valid(vv_v[0]), .vec_ready(vec_ready),
    .vec_data(vd_v[0]), .spurious(sp_v[0]), .busy(busy_v[0]),
    .ack_count(ac_v[0])
  );

  inta_sequencer #(.PULSE_W(3), .GAP_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .int_in(int_in), .int_en(int_en), .d_in(d_in),
    .inta(inta_v[1]), .vec_valid(vv_v[1]), .vec_ready(vec_ready),
    .vec_data(vd_v[1]), .spurious(sp_v[1]), .busy(busy_v[1]),
    .ack_count(ac_v[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference INTA shape: k cycles after the acknowledge begins.
  function automatic logic model_inta(int k, int p, int g);
    return (k >= 0 && k < p) || (k >= p + g && k < 2 * p + g);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; int_in = 1'b0; int_en = 1'b0; vec_ready = 1'b0; d_in = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    exp_ack[0] = 0;
    exp_ack[1] = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; int_in = 1'b0; int_en = 1'b0; vec_ready = 1'b0; d_in = 8'h00;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (inta_v[i] !== 1'b0) begin errors++; $display("FAIL reset_inta[%0d]: got %b expected 0", i, inta_v[i]); end
      checks++; if (vv_v[i] !== 1'b0) begin errors++; $display("FAIL reset_vec_valid[%0d]: got %b expected 0", i, vv_v[i]); end
      checks++; if (vd_v[i] !== 8'h00) begin errors++; $display("FAIL reset_vec_data[%0d]: got %h expected 00", i, vd_v[i]); end
      checks++; if (sp_v[i] !== 1'b0) begin errors++; $display("FAIL reset_spurious[%0d]: got %b expected 0", i, sp_v[i]); end
      checks++; if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy_v[i]); end
      checks++; if (ac_v[i] !== 8'h00) begin errors++; $display("FAIL reset_ack_count[%0d]: got %0d expected 0", i, ac_v[i]); end
    end
    do_reset();
  endtask

  // One complete interrupt on instance idx, starting from a quiet IDLE.
  task automatic run_full(input int idx, input int p, input int g,
                          input logic [7:0] vec, input logic [7:0] hold_din,
                          input int ready_delay, input logic early_ready);
    int hold_e;
    hold_e = 2 + 2 * p + g;
    int_in = 1'b1; int_en = 1'b1; d_in = vec; vec_ready = early_ready;
    for (int e = 0; e < hold_e; e++) begin
      step();
      checks++; if (inta_v[idx] !== model_inta(e - 2, p, g)) begin errors++; $display("FAIL seq_inta[%0d] E%0d: got %b expected %b", idx, e, inta_v[idx], model_inta(e - 2, p, g)); end
      checks++; if (busy_v[idx] !== (e >= 2)) begin errors++; $display("FAIL seq_busy[%0d] E%0d: got %b expected %b", idx, e, busy_v[idx], (e >= 2)); end
      checks++; if (vv_v[idx] !== 1'b0) begin errors++; $display("FAIL seq_early_valid[%0d] E%0d: got %b expected 0", idx, e, vv_v[idx]); end
      checks++; if (sp_v[idx] !== 1'b0) begin errors++; $display("FAIL seq_spurious[%0d] E%0d: got %b expected 0", idx, e, sp_v[idx]); end
      if (e == 2 + p) int_in = 1'b0;  // INT is ignored once the gap starts
    end
    step();
    checks++; if (vv_v[idx] !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] E%0d: got %b expected 1", idx, hold_e, vv_v[idx]); end
    checks++; if (vd_v[idx] !== vec) begin errors++; $display("FAIL hold_vec_data[%0d]: got %h expected %h", idx, vd_v[idx], vec); end
    checks++; if (inta_v[idx] !== 1'b0) begin errors++; $display("FAIL hold_inta[%0d]: got %b expected 0", idx, inta_v[idx]); end
    d_in = hold_din;
    for (int d = 0; d < ready_delay; d++) begin
      step();
      checks++; if (vv_v[idx] !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] c%0d: got %b expected 1", idx, d, vv_v[idx]); end
      checks++; if (vd_v[idx] !== vec) begin errors++; $display("FAIL stall_vec_data[%0d] c%0d: got %h expected %h", idx, d, vd_v[idx], vec); end
    end
    vec_ready = 1'b1;
    step();
    exp_ack[idx] = (exp_ack[idx] + 1) % 256;
    checks++; if (vv_v[idx] !== 1'b0) begin errors++; $display("FAIL accept_valid[%0d]: got %b expected 0", idx, vv_v[idx]); end
    checks++; if (busy_v[idx] !== 1'b0) begin errors++; $display("FAIL accept_busy[%0d]: got %b expected 0", idx, busy_v[idx]); end
    checks++; if (ac_v[idx] !== 8'(exp_ack[idx])) begin errors++; $display("FAIL accept_count[%0d]: got %0d expected %0d", idx, ac_v[idx], exp_ack[idx]); end
    for (int d = 0; d < 3; d++) begin
      step();
      checks++; if (ac_v[idx] !== 8'(exp_ack[idx])) begin errors++; $display("FAIL accept_once[%0d] c%0d: got %0d expected %0d", idx, d, ac_v[idx], exp_ack[idx]); end
      checks++; if (busy_v[idx] !== 1'b0) begin errors++; $display("FAIL post_busy[%0d] c%0d: got %b expected 0", idx, d, busy_v[idx]); end
    end
    vec_ready = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    run_full(0, 2, 1, 8'hAB, 8'hAB, 0, 1'b0);
    run_full(0, 2, 1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 1'b0);
  endtask

  task automatic test_spurious();
    logic [7:0] v;
    do_reset();
    v = 8'($urandom);
    run_full(0, 2, 1, v, 8'($urandom), 1, 1'b0);
    int_in = 1'b1; int_en = 1'b1; d_in = ~v;
    for (int e = 0; e < 10; e++) begin
      step();
      if (e == 1) int_in = 1'b0;
      checks++; if (inta_v[0] !== (e == 2 || e == 3)) begin errors++; $display("FAIL spur_inta E%0d: got %b expected %b", e, inta_v[0], (e == 2 || e == 3)); end
      checks++; if (sp_v[0] !== (e == 4)) begin errors++; $display("FAIL spur_pulse E%0d: got %b expected %b", e, sp_v[0], (e == 4)); end
      checks++; if (vv_v[0] !== 1'b0) begin errors++; $display("FAIL spur_valid E%0d: got %b expected 0", e, vv_v[0]); end
      checks++; if (vd_v[0] !== v) begin errors++; $display("FAIL spur_vec_data E%0d: got %h expected %h", e, vd_v[0], v); end
      checks++; if (ac_v[0] !== 8'(exp_ack[0])) begin errors++; $display("FAIL spur_count E%0d: got %0d expected %0d", e, ac_v[0], exp_ack[0]); end
    end
  endtask

  task automatic test_holdoff();
    do_reset();
    int_in = 1'b1; int_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++; if (inta_v[0] !== 1'b0) begin errors++; $display("FAIL holdoff_inta c%0d: got %b expected 0", c, inta_v[0]); end
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL holdoff_busy c%0d: got %b expected 0", c, busy_v[0]); end
      checks++; if (sp_v[0] !== 1'b0) begin errors++; $display("FAIL holdoff_spurious c%0d: got %b expected 0", c, sp_v[0]); end
    end
    int_en = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      checks++; if (inta_v[0] !== model_inta(e, 2, 1)) begin errors++; $display("FAIL enable_inta E%0d: got %b expected %b", e, inta_v[0], model_inta(e, 2, 1)); end
      checks++; if (sp_v[0] !== 1'b0) begin errors++; $display("FAIL enable_spurious E%0d: got %b expected 0", e, sp_v[0]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    run_full(0, 2, 1, 8'hAB, 8'h55, 10, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_full(0, 2, 1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
    int_in = 1'b1; int_en = 1'b1; d_in = 8'($urandom);
    repeat (6) step();
    checks++; if (inta_v[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_ack2: got %b expected 1", inta_v[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (inta_v[0] !== 1'b0) begin errors++; $display("FAIL midreset_inta: got %b expected 0", inta_v[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_v[0]); end
    checks++; if (vv_v[0] !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", vv_v[0]); end
    checks++; if (ac_v[0] !== 8'h00) begin errors++; $display("FAIL midreset_count: got %0d expected 0", ac_v[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ack[0] = 0;
    exp_ack[1] = 0;
    run_full(0, 2, 1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_params();
    do_reset();
    run_full(1, 3, 2, 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 1'b0);
    run_full(1, 3, 2, 8'($urandom), 8'($urandom), 0, 1'b1);
  endtask

  // Both instances run back-to-back from INT held high and ready tied high;
  // each sequence spans one IDLE cycle, the acknowledge window and one HOLD.
  task automatic test_back_to_back();
    int pp [2];
    int gg [2];
    int tt [2];
    int k, m, n_cycles;
    logic [7:0] din_edge;
    logic exp_inta, exp_vv, exp_busy;
    logic [7:0] exp_ac;
    pp[0] = 2; gg[0] = 1; pp[1] = 3; gg[1] = 2;
    for (int i = 0; i < 2; i++) tt[i] = 2 * pp[i] + gg[i] + 2;
    n_cycles = 2 + 256 * tt[1] + 2;
    do_reset();
    int_in = 1'b1; int_en = 1'b1; vec_ready = 1'b1; d_in = 8'($urandom);
    for (int e = 0; e < n_cycles; e++) begin
      din_edge = d_in;
      step();
      for (int i = 0; i < 2; i++) begin
        k = e - 2;
        m = (k >= 0) ? (k % tt[i]) : -1;
        exp_inta = (k >= 0) && model_inta(m, pp[i], gg[i]);
        exp_vv   = (k >= 0) && (m == 2 * pp[i] + gg[i]);
        exp_busy = (k >= 0) && (m != tt[i] - 1);
        exp_ac   = (e >= 1) ? 8'(((e - 1) / tt[i]) % 256) : 8'h00;
        checks++; if (inta_v[i] !== exp_inta) begin errors++; $display("FAIL b2b_inta[%0d] E%0d: got %b expected %b", i, e, inta_v[i], exp_inta); end
        checks++; if (vv_v[i] !== exp_vv) begin errors++; $display("FAIL b2b_valid[%0d] E%0d: got %b expected %b", i, e, vv_v[i], exp_vv); end
        checks++; if (busy_v[i] !== exp_busy) begin errors++; $display("FAIL b2b_busy[%0d] E%0d: got %b expected %b", i, e, busy_v[i], exp_busy); end
        checks++; if (ac_v[i] !== exp_ac) begin errors++; $display("FAIL b2b_count[%0d] E%0d: got %0d expected %0d", i, e, ac_v[i], exp_ac); end
        if (exp_vv) begin
          checks++; if (vd_v[i] !== din_edge) begin errors++; $display("FAIL b2b_vec_data[%0d] E%0d: got %h expected %h", i, e, vd_v[i], din_edge); end
        end
        if (e == 1 + 256 * tt[i]) begin
          checks++; if (ac_v[i] !== 8'h00) begin errors++; $display("FAIL b2b_wrap[%0d]: got %0d expected 0", i, ac_v[i]); end
        end
      end
      d_in = 8'($urandom);
    end
    int_in = 1'b0; vec_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_holdoff();
    test_hold();
    test_reset_mid();
    test_params();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
